// File: rtl/cadss_arb_pkg.sv
// ---------------------------------------------------------------------------
// cadss_arb_pkg
// Shared types and constants for the CADSS snooping-bus arbiter.
//   arb_state_e   : arbiter FSM states (IDLE, OWN, TURN)
//   NUM_PROCS_DEF : default number of bus requesters
//   TIMEOUT_DEF   : default watchdog limit in cycles
//   STAT_W        : width of the optional statistics counters
// ---------------------------------------------------------------------------
package cadss_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_e;

    localparam int NUM_PROCS_DEF = 4;
    localparam int TIMEOUT_DEF   = 64;
    localparam int STAT_W        = 32;

endpackage

// File: rtl/cadss_rr_pick.sv
// ---------------------------------------------------------------------------
// cadss_rr_pick
// Purely combinational rotate-priority encoder for the bus arbiter.
// Scans the request vector upward starting one past the previous winner and
// wrapping modulo NUM_PROCS, so the most recent owner has lowest priority.
// Ports:
//   req     (in,  NUM_PROCS) : request vector
//   last_id (in,  ID_W)      : index of the previous winner
//   any     (out, 1)         : at least one request is pending
//   winner  (out, ID_W)      : selected requester; 0 when no request
// ---------------------------------------------------------------------------
module cadss_rr_pick
    import cadss_arb_pkg::*;
#(
    parameter int NUM_PROCS = NUM_PROCS_DEF,
    parameter int ID_W      = $clog2(NUM_PROCS)
) (
    input  logic [NUM_PROCS-1:0] req,
    input  logic [ID_W-1:0]      last_id,
    output logic                 any,
    output logic [ID_W-1:0]      winner
);

    int               w_sum;
    logic [ID_W-1:0]  w_idx;
    logic             w_found;

    // Walk the NUM_PROCS positions after last_id in order; the first set bit
    // wins. The modulo keeps the index in range for non-power-of-two counts.
    always_comb begin
        any     = |req;
        winner  = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_PROCS; i++) begin
            w_sum = (int'(last_id) + i) % NUM_PROCS;
            w_idx = ID_W'(w_sum);
            if (!w_found && req[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cadss_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cadss_bus_arbiter
// Round-robin arbiter and transaction sequencer for the shared CADSS snooping
// bus. Grants one requester at a time, holds the grant until the transaction
// completes, the owner drops its request, or the watchdog expires, and then
// inserts a single turnaround cycle before the next owner.
// Ports:
//   clk         (in)             : bus clock
//   rst         (in)             : asynchronous active-high reset
//   req         (in,  NUM_PROCS) : per-processor level request
//   txn_done    (in)             : owner's transaction complete (OWN only)
//   grant       (out, NUM_PROCS) : one-hot ownership, zero when no owner
//   grant_id    (out, ID_W)      : owner index, zero when no owner
//   bus_busy    (out)            : high during OWN and TURN
//   timeout_err (out)            : one-cycle pulse on watchdog release
//   err_id      (out, ID_W)      : owner index captured at the last timeout
// Optional (macro CADSS_ARB_STATS_EN):
//   stat_grants (out, STAT_W)    : saturating count of entries into OWN
//   stat_wait   (out, STAT_W)    : saturating count of cycles with a pending
//                                  request and no active grant
// ---------------------------------------------------------------------------
module cadss_bus_arbiter
    import cadss_arb_pkg::*;
#(
    parameter int NUM_PROCS = NUM_PROCS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int ID_W      = $clog2(NUM_PROCS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PROCS-1:0] req,
    input  logic                 txn_done,
    output logic [NUM_PROCS-1:0] grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 bus_busy,
    output logic                 timeout_err,
    output logic [ID_W-1:0]      err_id
`ifdef CADSS_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_grants,
    output logic [STAT_W-1:0]    stat_wait
`endif
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    arb_state_e            r_state;
    arb_state_e            w_stateNext;
    logic [ID_W-1:0]       r_lastId;
    logic [WD_W-1:0]       r_watchdog;

    logic                  w_any;
    logic [ID_W-1:0]       w_winner;
    logic [NUM_PROCS-1:0]  w_oneHot;
    logic                  w_wdExpire;
    logic                  w_ownExit;

    logic [NUM_PROCS-1:0]  w_grantNext;
    logic [ID_W-1:0]       w_grantIdNext;
    logic                  w_busyNext;
    logic                  w_toErrNext;
    logic [ID_W-1:0]       w_errIdNext;
    logic [ID_W-1:0]       w_lastIdNext;
    logic [WD_W-1:0]       w_wdNext;

    cadss_rr_pick #(
        .NUM_PROCS (NUM_PROCS),
        .ID_W      (ID_W)
    ) u_pick (
        .req     (req),
        .last_id (r_lastId),
        .any     (w_any),
        .winner  (w_winner)
    );

    // Exit conditions for OWN. The watchdog counts completed owned cycles, so
    // reaching TIMEOUT-1 at an edge means the grant has been held TIMEOUT
    // cycles and must be released on that edge.
    always_comb begin
        w_oneHot           = '0;
        w_oneHot[w_winner] = 1'b1;
        w_wdExpire         = (r_watchdog == WD_W'(TIMEOUT - 1));
        w_ownExit          = txn_done | ~req[grant_id] | w_wdExpire;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. TURN always lasts one cycle and arbitrates directly
    // so back-to-back owners are separated by exactly one empty grant cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_any) w_stateNext = OWN;
            OWN:     if (w_ownExit) w_stateNext = TURN;
            TURN:    w_stateNext = w_any ? OWN : IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Output logic: computes the next value of every registered output.
    // A completion that coincides with watchdog expiry counts as a normal
    // completion, so timeout_err only fires when txn_done is low.
    always_comb begin
        w_grantNext   = '0;
        w_grantIdNext = '0;
        w_busyNext    = 1'b0;
        w_toErrNext   = 1'b0;
        w_errIdNext   = err_id;
        w_lastIdNext  = r_lastId;
        w_wdNext      = r_watchdog;
        case (r_state)
            IDLE, TURN: begin
                if (w_any) begin
                    w_grantNext   = w_oneHot;
                    w_grantIdNext = w_winner;
                    w_lastIdNext  = w_winner;
                    w_wdNext      = '0;
                    w_busyNext    = 1'b1;
                end
            end
            OWN: begin
                w_busyNext = 1'b1;
                if (w_ownExit) begin
                    if (w_wdExpire && !txn_done) begin
                        w_toErrNext = 1'b1;
                        w_errIdNext = grant_id;
                    end
                end else begin
                    w_grantNext   = grant;
                    w_grantIdNext = grant_id;
                    w_wdNext      = r_watchdog + 1'b1;
                end
            end
            default: begin
                w_busyNext = 1'b0;
            end
        endcase
    end

    // Registered outputs plus round-robin pointer and watchdog. The pointer
    // resets to the last requester so requester 0 wins the first round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            grant_id    <= '0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b0;
            err_id      <= '0;
            r_lastId    <= ID_W'(NUM_PROCS - 1);
            r_watchdog  <= '0;
        end else begin
            grant       <= w_grantNext;
            grant_id    <= w_grantIdNext;
            bus_busy    <= w_busyNext;
            timeout_err <= w_toErrNext;
            err_id      <= w_errIdNext;
            r_lastId    <= w_lastIdNext;
            r_watchdog  <= w_wdNext;
        end
    end

`ifdef CADSS_ARB_STATS_EN
    // Saturating statistics: grant entries are counted on the edge that moves
    // into OWN; wait cycles are cycles with a pending request but no grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants <= '0;
            stat_wait   <= '0;
        end else begin
            if (w_stateNext == OWN && r_state != OWN && stat_grants != '1) begin
                stat_grants <= stat_grants + 1'b1;
            end
            if (w_any && grant == '0 && stat_wait != '1) begin
                stat_wait <= stat_wait + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cadss_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cadss_bus_arbiter
// Directed bench for cadss_bus_arbiter (NUM_PROCS=4, TIMEOUT=64). Stimulus
// pushes the expected grant events (owner one-hot, owner id, hold length) and
// expected timeout err_id values into queues; a negedge monitor pops and
// compares them whenever the DUT starts or ends a grant or pulses timeout_err.
// Define CADSS_ARB_STATS_EN to also exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_cadss_bus_arbiter;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] id;
        int         hold;
    } grantEvt_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        txnDone;
    logic [3:0]  grant;
    logic [1:0]  grantId;
    logic        busBusy;
    logic        timeoutErr;
    logic [1:0]  errId;
`ifdef CADSS_ARB_STATS_EN
    logic [31:0] statGrants;
    logic [31:0] statWait;
`endif

    int          checks   = 0;
    int          failures = 0;
    grantEvt_t   expQ[$];
    int          errQ[$];

    logic [3:0]  prevGrant;
    logic        prevErr;
    int          holdCnt;
    int          curHold;

    cadss_bus_arbiter #(
        .NUM_PROCS (4),
        .TIMEOUT   (64),
        .ID_W      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .txn_done    (txnDone),
        .grant       (grant),
        .grant_id    (grantId),
        .bus_busy    (busBusy),
        .timeout_err (timeoutErr),
        .err_id      (errId)
`ifdef CADSS_ARB_STATS_EN
        ,
        .stat_grants (statGrants),
        .stat_wait   (statWait)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point shared by stimulus and monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One bus cycle: drive inputs, let the next rising edge sample them.
    task automatic applyStimulus(input logic [3:0] r, input logic d);
        req     = r;
        txnDone = d;
        @(posedge clk);
        #1;
    endtask

    // Remaining cycles of an ownership that lasts h cycles, ending in txn_done.
    task automatic runTxn(input logic [3:0] r, input int h);
        for (int i = 0; i < h - 1; i++) applyStimulus(r, 1'b0);
        applyStimulus(r, 1'b1);
    endtask

    task automatic doReset();
        rst     = 1'b1;
        req     = '0;
        txnDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic void pushGrant(input logic [3:0] g, input logic [1:0] id,
                                      input int h);
        grantEvt_t e;
        e.grant = g;
        e.id    = id;
        e.hold  = h;
        expQ.push_back(e);
    endfunction

    // Monitor: compares each new grant against the scoreboard head, measures
    // how long it is held, and checks every timeout pulse and its err_id.
    always @(negedge clk) begin
        grantEvt_t e;
        int        expErr;
        if (rst) begin
            prevGrant = '0;
            prevErr   = 1'b0;
            holdCnt   = 0;
            curHold   = 0;
        end else begin
            if (grant != '0 && prevGrant == '0) begin
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                end else begin
                    e.grant = '0;
                    e.id    = '0;
                    e.hold  = 0;
                end
                checkOutput("grant_onehot", 32'(grant), 32'(e.grant));
                checkOutput("grant_id", 32'(grantId), 32'(e.id));
                curHold = e.hold;
                holdCnt = 1;
            end else if (grant != '0) begin
                holdCnt++;
            end else if (prevGrant != '0) begin
                checkOutput("grant_hold_cycles", 32'(holdCnt), 32'(curHold));
            end
            if (timeoutErr) begin
                expErr = (errQ.size() > 0) ? errQ.pop_front() : 32'hDEAD;
                checkOutput("timeout_err_id", 32'(errId), 32'(expErr));
                checkOutput("timeout_pulse_width", 32'(prevErr), 32'd0);
            end
            prevGrant = grant;
            prevErr   = timeoutErr;
        end
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        txnDone = 1'b0;
        doReset();

        // Reset state.
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_grant_id", 32'(grantId), 32'd0);
        checkOutput("rst_bus_busy", 32'(busBusy), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeoutErr), 32'd0);
        checkOutput("rst_err_id", 32'(errId), 32'd0);

        // txn_done in IDLE is ignored.
        applyStimulus(4'b0000, 1'b1);
        checkOutput("idle_done_ignored", 32'(busBusy), 32'd0);

        // Single requester: one-cycle latency, three owned cycles, TURN, IDLE.
        $display("[TB] single requester");
        pushGrant(4'b0001, 2'd0, 3);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("s1_latency_grant", 32'(grant), 32'h1);
        checkOutput("s1_busy_own", 32'(busBusy), 32'd1);
        runTxn(4'b0001, 3);
        checkOutput("s1_turn_grant", 32'(grant), 32'd0);
        checkOutput("s1_turn_busy", 32'(busBusy), 32'd1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("s1_idle_busy", 32'(busBusy), 32'd0);

        // All four requesting: strict rotation 0,1,2,3,0 with one TURN gap.
        $display("[TB] round robin");
        doReset();
        pushGrant(4'b0001, 2'd0, 2);
        pushGrant(4'b0010, 2'd1, 2);
        pushGrant(4'b0100, 2'd2, 2);
        pushGrant(4'b1000, 2'd3, 2);
        pushGrant(4'b0001, 2'd0, 2);
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 4; k++) begin
            runTxn(4'b1111, 2);
            checkOutput("rr_turn_gap", 32'(grant), 32'd0);
            applyStimulus(4'b1111, 1'b0);
        end
        runTxn(4'b1111, 2);
        applyStimulus(4'b0000, 1'b0);

        // Wrap: owner 1 then {0,1} requesting picks 0; lone requester re-wins.
        $display("[TB] wrap and re-win");
        doReset();
        pushGrant(4'b0010, 2'd1, 2);
        pushGrant(4'b0001, 2'd0, 2);
        pushGrant(4'b0001, 2'd0, 2);
        applyStimulus(4'b0010, 1'b0);
        runTxn(4'b0010, 2);
        applyStimulus(4'b0011, 1'b0);
        checkOutput("wrap_grant_id", 32'(grantId), 32'd0);
        runTxn(4'b0001, 2);
        applyStimulus(4'b0001, 1'b0);
        runTxn(4'b0001, 2);
        applyStimulus(4'b0000, 1'b0);

        // Watchdog: 64 owned cycles without completion forces release.
        $display("[TB] watchdog");
        doReset();
        pushGrant(4'b0100, 2'd2, 64);
        errQ.push_back(2);
        applyStimulus(4'b0100, 1'b0);
        for (int i = 0; i < 64; i++) applyStimulus(4'b0100, 1'b0);
        checkOutput("wd_grant_released", 32'(grant), 32'd0);
        checkOutput("wd_err_pulse", 32'(timeoutErr), 32'd1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("wd_err_cleared", 32'(timeoutErr), 32'd0);
        checkOutput("wd_err_id_holds", 32'(errId), 32'd2);

        // Completion on the expiry edge is a normal completion.
        pushGrant(4'b0100, 2'd2, 64);
        applyStimulus(4'b0100, 1'b0);
        for (int i = 0; i < 63; i++) applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("wd_done_no_err", 32'(timeoutErr), 32'd0);
        applyStimulus(4'b0000, 1'b0);

        // Abort: owner 1 drops its request; a non-owner request is ignored.
        $display("[TB] abort and async reset");
        doReset();
        pushGrant(4'b0010, 2'd1, 2);
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0110, 1'b0);
        checkOutput("abort_owner_kept", 32'(grantId), 32'd1);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("abort_grant", 32'(grant), 32'd0);
        checkOutput("abort_no_err", 32'(timeoutErr), 32'd0);
        applyStimulus(4'b0000, 1'b0);

        // Asynchronous reset in the middle of an ownership.
        pushGrant(4'b0010, 2'd1, 0);
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0110, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_grant", 32'(grant), 32'd0);
        checkOutput("async_rst_busy", 32'(busBusy), 32'd0);
        checkOutput("async_rst_grant_id", 32'(grantId), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pushGrant(4'b0001, 2'd0, 2);
        applyStimulus(4'b0111, 1'b0);
        checkOutput("post_rst_winner", 32'(grantId), 32'd0);
        runTxn(4'b0001, 2);
        applyStimulus(4'b0000, 1'b0);

`ifdef CADSS_ARB_STATS_EN
        // Two requesters, four grants: 1 IDLE wait + 3 TURN waits = 4.
        $display("[TB] statistics");
        doReset();
        pushGrant(4'b0001, 2'd0, 2);
        pushGrant(4'b0010, 2'd1, 2);
        pushGrant(4'b0001, 2'd0, 2);
        pushGrant(4'b0010, 2'd1, 2);
        applyStimulus(4'b0011, 1'b0);
        for (int k = 0; k < 3; k++) begin
            runTxn(4'b0011, 2);
            applyStimulus(4'b0011, 1'b0);
        end
        runTxn(4'b0011, 2);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("stat_grants", statGrants, 32'd4);
        checkOutput("stat_wait", statWait, 32'd4);
`endif

        // Every expected event must have been consumed by the monitor.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("grant_events_left", 32'(expQ.size()), 32'd0);
        checkOutput("timeout_events_left", 32'(errQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cadss_bus_arbiter.md
Name: cadss_bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared snooping bus in the CADSS interconnect.
- Sits between the per-processor cache controllers and the bus datapath.
- Grants exclusive bus ownership to one requester at a time and holds it until the transaction completes, the requester aborts, or a watchdog fires.
- Inserts one turnaround cycle between owners.

Parameters:
- NUM_PROCS, 4, number of requesters (2..16).
- TIMEOUT, 64, max cycles a grant may be held before forced release (>=2).
- ID_W, $clog2(NUM_PROCS), width of the grant index.

Ports:
- clk  in  1  bus clock, advanced one edge per simulator tick.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_PROCS  per-processor bus request, level; held until granted transaction ends.
- txn_done  in  1  current owner's transaction complete; single-cycle pulse, valid only in OWN.
- grant  out  NUM_PROCS  one-hot ownership; all-zero when no owner.
- grant_id  out  ID_W  index of owner; 0 when no owner.
- bus_busy  out  1  high in OWN and TURN.
- timeout_err  out  1  one-cycle pulse when watchdog forces release.
- err_id  out  ID_W  owner index captured at timeout; holds until next timeout.

Behaviour:
- All outputs registered. Reset values: grant=0, grant_id=0, bus_busy=0, timeout_err=0, err_id=0, FSM=IDLE. Round-robin pointer last_id resets to NUM_PROCS-1, so requester 0 wins first.
- FSM states IDLE, OWN, TURN.
- IDLE: if any req bit is set, the next edge selects the winner = first set req bit scanning upward from last_id+1, wrapping modulo NUM_PROCS.
  - On that edge: grant one-hot asserted, grant_id = winner, last_id = winner, watchdog = 0, go OWN.
  - Latency: req sampled high in cycle N gives grant high in cycle N+1.
- OWN: watchdog increments each cycle. Exit to TURN on the first edge where any of the following holds, with grant deasserted on that edge:
  - (a) txn_done=1.
  - (b) req[grant_id]=0 (abort).
  - (c) watchdog == TIMEOUT-1. This also pulses timeout_err for one cycle and loads err_id = grant_id.
- Simultaneous txn_done and timeout: treated as completion, no timeout_err.
- TURN: exactly one cycle, bus_busy=1, grant=0. Then:
  - If any req is set, arbitrate directly (as in IDLE) and enter OWN.
  - Otherwise go to IDLE.
- Consecutive grants are therefore separated by exactly one idle-grant cycle.
- Fairness: a requester holding req continuously is granted within NUM_PROCS arbitration rounds.
- txn_done outside OWN is ignored.
- req changes of non-owners during OWN have no effect until the next arbitration.
- Single requester with req held high re-wins after TURN every time.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronous). last_id returns to NUM_PROCS-1; the watchdog clears.
- Watchdog width: $clog2(TIMEOUT)+1 bits, no wrap inside OWN.

Optional Feature:
- Macro CADSS_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_grants (32-bit): count of entries into OWN.
  - stat_wait (32-bit): cycles in which any req bit is set and no grant is active.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cadss_arb_pkg holds:
  - arb_state_e enum {IDLE, OWN, TURN}.
  - Default parameter constants NUM_PROCS_DEF=4 and TIMEOUT_DEF=64.
  - Stat counter width constant STAT_W=32.
- One sub-module, cadss_rr_pick: purely combinational rotate-priority encoder.
  - Inputs: req, last_id. Outputs: any, winner.
- The FSM, watchdog and registers stay in cadss_bus_arbiter.

Test Plan:
- Reset then req=4'b0001 at cycle 2 -> grant=0001, grant_id=0 at cycle 3; txn_done at cycle 5 -> grant=0 at cycle 6 (TURN), IDLE at cycle 7.
- req=4'b1111 held, txn_done pulsed 2 cycles after each grant -> grant order 0,1,2,3,0 with exactly one grant=0 cycle between owners.
- last_id=1, req=4'b0011 -> grant_id=0 (wrap); then req=4'b0001 only -> owner 0 again after TURN.
- req=4'b0100 held with no txn_done, TIMEOUT=64 -> grant drops after 64 cycles of ownership; timeout_err pulses once, err_id=2.
- Owner 1 drops req mid-OWN -> grant clears next edge, no timeout_err; rst pulsed during OWN -> grant=0 and bus_busy=0 immediately; the next grant goes to requester 0 if requesting.
- With CADSS_ARB_STATS_EN: req=4'b0011, done after 2 cycles each, 4 grants -> stat_grants=4; stat_wait equals the number of cycles in which any req was set and grant=0.
